// File: rtl/lcd_zoom_line_buffer.sv
// Ping-pong line buffer with 2x nearest-neighbour upscale for the zoomed LCD driver.
// Define LCD_ZOOM_UNDERRUN_EN to return UNDERRUN_RGB for unfilled rows and flag underrun.
module lcd_zoom_line_buffer #(
  parameter int unsigned SRC_W        = 320,
  parameter int unsigned SRC_H        = 240,
  parameter logic [23:0] UNDERRUN_RGB = 24'hFF00FF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lcd_vs,
  input  logic        lcd_request,
  input  logic [10:0] lcd_xpos,
  input  logic [10:0] lcd_ypos,
  output logic [23:0] lcd_data,
  output logic        src_frame_start,
  input  logic [23:0] src_data,
  input  logic        src_valid,
  output logic        src_ready,
  output logic        underrun
);

  localparam int unsigned XW = $clog2(SRC_W);
  localparam int unsigned LW = $clog2(SRC_H);
  localparam logic [XW-1:0] LastX    = XW'(SRC_W - 1);
  localparam logic [LW-1:0] LastLine = LW'(SRC_H - 1);

  typedef enum logic [1:0] {StIdle, StStart, StFill, StDone} state_e;

  state_e          state_q;
  logic [XW-1:0]   wr_x_q;
  logic [LW-1:0]   wr_line_q;
  logic [1:0]      full_q;
  logic            vs_q, vs_fall_q;
  logic            req_q, row_bank_q, row_even_q;

  logic [23:0]     bank0_mem [SRC_W];
  logic [23:0]     bank1_mem [SRC_W];

  logic            beat;
  logic [10:0]     ypos_m1;
  logic            rd_bank;
  logic [XW-1:0]   rd_addr;
  logic [23:0]     rd_word;
  logic            rel_en;
  logic            unused_bits;

  assign src_ready = (state_q == StFill) && !full_q[wr_line_q[0]];
  assign beat      = src_valid && src_ready;

  // Row y shows source line (y-1)>>1, which lives in bank ((y-1)>>1)[0].
  assign ypos_m1 = lcd_ypos - 11'd1;
  assign rd_bank = ypos_m1[1];
  assign rd_addr = XW'(lcd_xpos >> 1);
  assign rd_word = rd_bank ? bank1_mem[rd_addr] : bank0_mem[rd_addr];

  // End of the second display copy of a line frees its bank for refill.
  assign rel_en = req_q && !lcd_request && row_even_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      wr_x_q          <= '0;
      wr_line_q       <= '0;
      full_q          <= '0;
      vs_q            <= 1'b0;
      vs_fall_q       <= 1'b0;
      src_frame_start <= 1'b0;
    end else begin
      vs_q            <= lcd_vs;
      vs_fall_q       <= vs_q && !lcd_vs;
      src_frame_start <= 1'b0;
      if (rel_en) full_q[row_bank_q] <= 1'b0;
      if (vs_fall_q) begin
        state_q         <= StStart;
        src_frame_start <= 1'b1;
      end else begin
        unique case (state_q)
          StStart: begin
            full_q    <= '0;
            wr_x_q    <= '0;
            wr_line_q <= '0;
            state_q   <= StFill;
          end
          StFill: begin
            if (beat) begin
              if (wr_x_q == LastX) begin
                full_q[wr_line_q[0]] <= 1'b1;
                wr_x_q               <= '0;
                wr_line_q            <= wr_line_q + 1'b1;
                if (wr_line_q == LastLine) state_q <= StDone;
              end else begin
                wr_x_q <= wr_x_q + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      if (wr_line_q[0]) bank1_mem[wr_x_q] <= src_data;
      else              bank0_mem[wr_x_q] <= src_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q      <= 1'b0;
      row_bank_q <= 1'b0;
      row_even_q <= 1'b0;
    end else begin
      req_q <= lcd_request;
      if (lcd_request) begin
        row_bank_q <= rd_bank;
        row_even_q <= !lcd_ypos[0];
      end
    end
  end

`ifdef LCD_ZOOM_UNDERRUN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            lcd_data <= '0;
    else if (!lcd_request) lcd_data <= '0;
    else                   lcd_data <= full_q[rd_bank] ? rd_word : UNDERRUN_RGB;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                underrun <= 1'b0;
    else if (state_q == StStart)               underrun <= 1'b0;
    else if (lcd_request && !full_q[rd_bank])  underrun <= 1'b1;
  end

  assign unused_bits = ^{ypos_m1[10:2], ypos_m1[0]};
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            lcd_data <= '0;
    else if (!lcd_request) lcd_data <= '0;
    else                   lcd_data <= rd_word;
  end

  assign underrun    = 1'b0;
  assign unused_bits = ^{ypos_m1[10:2], ypos_m1[0], UNDERRUN_RGB};
`endif

endmodule

// File: tb/tb_lcd_zoom_line_buffer.sv
// Directed bench for lcd_zoom_line_buffer on a small 8x6 source frame.
module tb_lcd_zoom_line_buffer;

  localparam int W = 8;
  localparam int H = 6;

  logic        clk;
  logic        rst_n;
  logic        lcd_vs;
  logic        lcd_request;
  logic [10:0] lcd_xpos;
  logic [10:0] lcd_ypos;
  logic [23:0] lcd_data;
  logic        src_frame_start;
  logic [23:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic        underrun;

  int n_checks = 0;
  int n_fail   = 0;
  int beats    = 0;
  int sfs_cnt  = 0;
  int limit    = 0;
  int seed     = 0;
  bit src_en   = 0;

  lcd_zoom_line_buffer #(
    .SRC_W       (W),
    .SRC_H       (H),
    .UNDERRUN_RGB(24'hFF00FF)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lcd_vs         (lcd_vs),
    .lcd_request    (lcd_request),
    .lcd_xpos       (lcd_xpos),
    .lcd_ypos       (lcd_ypos),
    .lcd_data       (lcd_data),
    .src_frame_start(src_frame_start),
    .src_data       (src_data),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .underrun       (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pix(input int x, input int l, input int s);
    return 24'(x + (l << 12) + (s << 20));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Upstream source: restarts at (0,0) on src_frame_start, sends up to 'limit' beats.
  initial begin
    int  sx = 0;
    int  sl = 0;
    bit  acc;
    src_valid = 1'b0;
    src_data  = '0;
    forever begin
      @(negedge clk);
      acc = src_valid && src_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        beats++;
        if (sx == W - 1) begin
          sx = 0;
          sl++;
        end else begin
          sx++;
        end
      end
      if (src_frame_start) begin
        sx    = 0;
        sl    = 0;
        beats = 0;
      end
      src_valid = src_en && (beats < limit);
      src_data  = pix(sx, sl, seed);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (src_frame_start) sfs_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic vs_pulse();
    lcd_vs = 1'b0;
    tick();
    check("sfs_early", 32'(src_frame_start), 0);
    tick();
    check("sfs_pulse", 32'(src_frame_start), 1);
    lcd_vs = 1'b1;
    tick();
    check("sfs_end", 32'(src_frame_start), 0);
  endtask

  task automatic wait_beats(input string tag, input int target, input int budget);
    int n = 0;
    while (beats != target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(beats), 32'(target));
  endtask

  // Pixels with source x below split come from (lo_line, lo_seed), the rest from (hi_line, hi_seed).
  task automatic show_row(input int y, input int split, input int lo_line, input int lo_seed,
                          input int hi_line, input int hi_seed);
    logic [23:0] exp;
    for (int x = 0; x < 2 * W; x++) begin
      lcd_request = 1'b1;
      lcd_xpos    = 11'(x);
      lcd_ypos    = 11'(y);
      tick();
      exp = (x / 2 < split) ? pix(x / 2, lo_line, lo_seed) : pix(x / 2, hi_line, hi_seed);
      check($sformatf("row%0d_x%0d", y, x), 32'(lcd_data), 32'(exp));
    end
    lcd_request = 1'b0;
    lcd_xpos    = '0;
    lcd_ypos    = '0;
    tick();
    check($sformatf("row%0d_idle_zero", y), 32'(lcd_data), 0);
  endtask

  task automatic row(input int y, input int s);
    show_row(y, W, (y - 1) / 2, s, 0, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    lcd_vs      = 1'b1;
    lcd_request = 1'b0;
    lcd_xpos    = '0;
    lcd_ypos    = '0;
    repeat (3) tick();
    check("rst_lcd_data", 32'(lcd_data), 0);
    check("rst_src_ready", 32'(src_ready), 0);
    check("rst_sfs", 32'(src_frame_start), 0);
    check("rst_underrun", 32'(underrun), 0);

    rst_n = 1'b1;
    repeat (10) tick();
    check("idle_src_ready", 32'(src_ready), 0);
    check("idle_sfs_count", 32'(sfs_cnt), 0);
    check("idle_lcd_data", 32'(lcd_data), 0);

    // Frame 1: full-rate source, both banks fill then back-pressure.
    seed   = 1;
    limit  = W * H;
    src_en = 1'b1;
    vs_pulse();
    wait_beats("f1_fill", 2 * W, 60);
    tick();
    tick();
    check("f1_backpressure", 32'(src_ready), 0);
    check("f1_beats_held", 32'(beats), 32'(2 * W));
    check("f1_sfs_count", 32'(sfs_cnt), 1);
    row(1, 1);
    row(2, 1);
    check("f1_release_ready", 32'(src_ready), 1);
    for (int y = 3; y <= 2 * H; y++) begin
      row(y, 1);
      tick();
    end
    check("f1_beats_total", 32'(beats), 32'(W * H));
    check("f1_done_ready", 32'(src_ready), 0);

    // Frame 2: source stalls three pixels into line 1.
    seed  = 2;
    limit = W + 3;
    vs_pulse();
    wait_beats("f2_stall", W + 3, 60);
    row(1, 2);
    row(2, 2);
    check("f2_underrun_clean", 32'(underrun), 0);
`ifdef LCD_ZOOM_UNDERRUN_EN
    for (int x = 0; x < 2 * W; x++) begin
      lcd_request = 1'b1;
      lcd_xpos    = 11'(x);
      lcd_ypos    = 11'd3;
      tick();
      check($sformatf("row3_underrun_x%0d", x), 32'(lcd_data), 32'h00FF00FF);
    end
    lcd_request = 1'b0;
    tick();
    check("f2_underrun_set", 32'(underrun), 1);
`else
    show_row(3, 3, 1, 2, 5, 1);
    check("f2_underrun_tied", 32'(underrun), 0);
`endif

    // Frame 3: aborted mid-line by a new vs edge.
    seed  = 3;
    limit = 2 * W + 4;
    vs_pulse();
    check("f3_underrun_clear", 32'(underrun), 0);
    wait_beats("f3_fill", 2 * W, 60);
    row(1, 3);
    row(2, 3);
    wait_beats("f3_midline", 2 * W + 4, 40);
    check("f3_midline_ready", 32'(src_ready), 1);

    // Frame 4: resync must clear counters and flags and display cleanly.
    seed  = 4;
    limit = W * H;
    vs_pulse();
    wait_beats("f4_fill", 2 * W, 60);
    tick();
    tick();
    check("f4_backpressure", 32'(src_ready), 0);
    check("f4_sfs_count", 32'(sfs_cnt), 4);
    for (int y = 1; y <= 2 * H; y++) begin
      row(y, 4);
      tick();
    end
    check("f4_beats_total", 32'(beats), 32'(W * H));
    check("f4_done_ready", 32'(src_ready), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_zoom_line_buffer.md
# lcd_zoom_line_buffer

Ping-pong line buffer and 2x nearest-neighbour upscaler that feeds the zoomed LCD driver's pixel request port. It accepts a SRC_W x SRC_H source frame over a valid/ready stream, typically from the SDRAM read FIFO. It returns one 24-bit pixel per driver request, one cycle later, which matches the driver's one-cycle request lead. Each source pixel is emitted twice horizontally and each source line twice vertically, so 320x240 fills the 640x480 window.

## Interface
- SRC_W, 320: source pixels per line; display window is 2*SRC_W wide.
- SRC_H, 240: source lines per frame; display window is 2*SRC_H tall.
- UNDERRUN_RGB, 24'hFF00FF: colour emitted when a requested line is not ready (macro-enabled only).
- clk  in  1  pixel clock, same clock as the LCD driver.
- rst_n  in  1  asynchronous, active-low reset.
- lcd_vs  in  1  driver vertical sync, active low; its falling edge marks frame start.
- lcd_request  in  1  driver data request.
- lcd_xpos  in  11  requested x, 0..2*SRC_W-1, valid while lcd_request is high.
- lcd_ypos  in  11  requested y, 1..2*SRC_H, valid while lcd_request is high.
- lcd_data  out  24  pixel, registered, valid the cycle after a request.
- src_frame_start  out  1  one-cycle pulse: upstream restarts at pixel (0,0).
- src_data  in  24  source pixel.
- src_valid  in  1  source pixel valid.
- src_ready  out  1  buffer can accept a pixel.
- underrun  out  1  sticky per-frame underrun flag (macro-enabled only).

## Operation
- Storage: two line RAMs, bank0 and bank1, each SRC_W x 24, with a synchronous read port. Source line k is written to bank k[0]. Each bank has a full flag.
- Write FSM:
  - IDLE: src_ready=0. On a detected lcd_vs falling edge (registered lcd_vs 1 -> 0), go to START.
  - START: pulse src_frame_start for 1 cycle; clear both full flags, wr_x and wr_line; go to FILL.
  - FILL: src_ready = ~full[wr_line[0]]. A beat is accepted on src_valid & src_ready; it writes RAM[wr_line[0]][wr_x] and increments wr_x.
    - When wr_x==SRC_W-1 is accepted: set full[wr_line[0]], wr_x=0, increment wr_line.
    - If that was line SRC_H-1, go to DONE.
  - DONE: src_ready=0. On a vs falling edge, go to START.
- Frame resync: a vs falling edge in any state other than IDLE or DONE aborts the partial frame and goes to START. Partially written data is discarded.
- Read path:
  - Source line index = (lcd_ypos-1)>>1; read bank b = that index's bit 0; read address = lcd_xpos>>1.
  - lcd_data is loaded from RAM when lcd_request is high, otherwise loaded with 0.
- Bank release: lcd_request and the in-row ypos are registered. On a request falling edge (end of a display row) with the registered ypos even (second copy of a line), clear full[b] of that row.
- Release and fill-complete on opposite banks in the same cycle both take effect. The same bank cannot coincide, because fill of a bank requires it to be empty.
- Counter widths: wr_x is clog2(SRC_W) bits; wr_line is clog2(SRC_H) bits. No wrap occurs inside a frame; both reset only in START.

## Timing
- Reset values: lcd_data=0, src_ready=0, src_frame_start=0, underrun=0; FSM in IDLE; full flags cleared.
- Read latency: exactly 1 clk from lcd_request/xpos to lcd_data.
- src_frame_start is asserted 2 clk after the vs falling edge: 1 clk for edge detect, then the START cycle.
- Write throughput: 1 pixel per clk while src_ready is high.
- Back-pressure: src_ready falls in the cycle after the last beat fills a bank whose partner is still full.
- Reset mid-frame: all state clears immediately. The block waits for the next vs falling edge before requesting data.

## Configuration
- LCD_ZOOM_UNDERRUN_EN:
  - Defined: a request to a row whose bank is not full returns UNDERRUN_RGB, 1 clk later, and sets underrun. underrun clears only in START.
  - Undefined: stale RAM content is returned, and underrun is tied to 0.

## Test plan
- Reset release, no vs edge: src_ready=0, lcd_data=0, src_frame_start never pulses.
- Vs falling edge; source streams pixel value = x + (line<<12) at full rate: src_frame_start pulses once; both banks fill; src_ready drops after 640 beats.
- Display row ypos=1, xpos 0..639: lcd_data sequence 0,0,1,1,...,319,319, each 1 clk late. Row ypos=2 repeats it. After row 2 ends, bank0 is released and src_ready rises.
- Full frame of 480 rows with the source kept just ahead: every output equals source pixel (xpos>>1, (ypos-1)>>1); FSM ends in DONE.
- Source stalled (src_valid=0) before line 1 completes, LCD_ZOOM_UNDERRUN_EN defined: row ypos=3 outputs 24'hFF00FF and underrun=1. underrun clears at the next START.
- Vs falling edge mid-line (wr_x=100, wr_line=5): FSM goes to START, counters and flags clear, and the next frame displays correctly.
